// File: rtl/div_unit.sv
// 32-bit restoring divider (DIV/DIVU/REM/REMU): 33 cycles start-to-valid, 1 cycle for fast special cases.
// No backpressure: start_i is ignored while busy, kill_i aborts immediately.
module div_unit #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [32:0] dvs_q, dvs_d;
    logic        rem_op_q, rem_op_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
    logic [31:0] result_q, result_d;
    logic        valid_q, valid_d;

    // Operand decode for the accepting cycle.
    logic        signed_in, a_neg, b_neg, in_dz, in_ovf;
    logic [31:0] a_mag, b_mag, special_res;

    always_comb begin
        signed_in = ~op_i[0];
        a_neg     = signed_in & a_i[31];
        b_neg     = signed_in & b_i[31];
        a_mag     = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag     = b_neg ? (~b_i + 32'd1) : b_i;
        in_dz     = (b_i == 32'd0);
        in_ovf    = signed_in && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        if (in_dz) begin
            special_res = op_i[1] ? a_i : 32'hFFFF_FFFF;
        end else begin
            special_res = op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step; a set rem_q[32] means the shifted value exceeds any divisor.
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        ge;
    logic [32:0] rem_nx;
    logic [31:0] quot_nx, q_fin, r_fin, fin_res;

    always_comb begin
        rem_sh  = {rem_q[31:0], quot_q[31]};
        diff    = {1'b0, rem_sh} - {1'b0, dvs_q};
        ge      = rem_q[32] | ~diff[33];
        rem_nx  = ge ? diff[32:0] : rem_sh;
        quot_nx = {quot_q[30:0], ge};
        // Iterated divide-by-zero yields all-ones magnitude; the sign fix must not touch it.
        q_fin   = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quot_nx + 32'd1) : quot_nx);
        r_fin   = r_neg_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
        fin_res = rem_op_q ? r_fin : q_fin;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvs_d    = dvs_q;
        rem_op_d = rem_op_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_op_d = op_i[1];
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    dz_d     = in_dz;
                    if (FAST_SPECIAL && (in_dz || in_ovf)) begin
                        state_d  = DONE;
                        result_d = special_res;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = 6'd32;
                        rem_d   = 33'd0;
                        quot_d  = a_mag;
                        dvs_d   = {1'b0, b_mag};
                    end
                end
            end
            CALC: begin
                cnt_d  = cnt_q - 6'd1;
                rem_d  = rem_nx;
                quot_d = quot_nx;
                if (cnt_q == 6'd1) begin
                    state_d  = DONE;
                    result_d = fin_res;
                    valid_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (kill_i) begin
            state_d  = IDLE;
            cnt_d    = 6'd0;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 33'd0;
            quot_q   <= 32'd0;
            dvs_q    <= 33'd0;
            rem_op_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvs_q    <= dvs_d;
            rem_op_q <= rem_op_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: fast-special and iterating-special instances share stimulus, scoreboarded per instance.
module tb_div_unit;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy_f, valid_f, busy_s, valid_s;
    logic [31:0] res_f, res_s;

    int errors = 0;
    int checks = 0;
    logic [31:0] qf[$];
    logic [31:0] qs[$];
    logic [31:0] last_f, last_s;

    always #5 clk = ~clk;

    div_unit #(.FAST_SPECIAL(1'b1)) dut_f (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .kill_i(kill), .busy_o(busy_f), .valid_o(valid_f), .result_o(res_f)
    );

    div_unit #(.FAST_SPECIAL(1'b0)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .kill_i(kill), .busy_o(busy_s), .valid_o(valid_s), .result_o(res_s)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return sx / sy;
            OP_DIVU: return x / y;
            OP_REM:  return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic int fast_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 0;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Drives a one-cycle start; returns #1 after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
        op = o; a = x; b = y; start = 1'b1;
        if (push) begin
            qf.push_back(model(o, x, y));
            qs.push_back(model(o, x, y));
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int lat_f, input int lat_s, input bit poke);
        bit got_f = 1'b0;
        bit got_s = 1'b0;
        logic [31:0] e;
        chk({tag, "_busy_f"}, {31'd0, busy_f}, 32'd1);
        chk({tag, "_busy_s"}, {31'd0, busy_s}, 32'd1);
        for (int k = 0; k <= 40; k++) begin
            if (poke) begin
                if (k == 5 || k == 32) begin
                    start = 1'b1; op = OP_DIVU; a = 32'd999; b = 32'd3;
                end else begin
                    start = 1'b0;
                end
            end
            if (valid_f) begin
                if (qf.size() == 0) chk({tag, "_spurious_f"}, {31'd0, valid_f}, 32'd0);
                else begin
                    e = qf.pop_front();
                    last_f = e;
                    chk({tag, "_res_f"}, res_f, e);
                    chk({tag, "_lat_f"}, 32'(k), 32'(lat_f));
                    got_f = 1'b1;
                end
            end
            if (valid_s) begin
                if (qs.size() == 0) chk({tag, "_spurious_s"}, {31'd0, valid_s}, 32'd0);
                else begin
                    e = qs.pop_front();
                    last_s = e;
                    chk({tag, "_res_s"}, res_s, e);
                    chk({tag, "_lat_s"}, 32'(k), 32'(lat_s));
                    got_s = 1'b1;
                end
            end
            if (got_f && got_s) break;
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, {30'd0, got_f, got_s}, 32'd3);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_idle_f"}, {30'd0, busy_f, valid_f}, 32'd0);
        chk({tag, "_idle_s"}, {30'd0, busy_s, valid_s}, 32'd0);
    endtask

    task automatic quiet(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_novalid"}, {30'd0, valid_f, valid_s}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start_op(o, x, y, 1'b1);
        wait_result(tag, fast_lat(o, x, y), 32, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        last_f = 32'd0; last_s = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_f", {busy_f, valid_f, res_f[29:0]}, 32'd0);
        chk("rst_res_f", res_f, 32'd0);
        chk("rst_s", {busy_s, valid_s, res_s[29:0]}, 32'd0);
        chk("rst_res_s", res_s, 32'd0);
        rst = 1'b0;

        run("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        run("divu_dz", OP_DIVU, 32'h1234, 32'd0);
        run("remu_dz", OP_REMU, 32'h1234, 32'd0);
        run("div_dz_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0);
        run("rem_dz_neg", OP_REM, 32'hFFFF_FFFB, 32'd0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run("remu_5_m1", OP_REMU, 32'd5, 32'hFFFF_FFFF);
        run("divu_bigdiv", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
        run("remu_bigdiv", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001);
        run("div_neg_neg", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

        // Kill sampled 10 edges after acceptance.
        start_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", {30'd0, busy_f, busy_s}, 32'd0);
        chk("kill_valid", {30'd0, valid_f, valid_s}, 32'd0);
        chk("kill_hold_f", res_f, last_f);
        chk("kill_hold_s", res_s, last_s);
        run("after_kill", OP_DIVU, 32'd1000, 32'd9);

        // Starts during CALC and DONE must be dropped.
        start_op(OP_DIV, 32'd12345, 32'hFFFF_FFFD, 1'b1);
        wait_result("poke", 32, 32, 1'b1);
        quiet("poke_q", 36);

        // Kill during DONE of the fast path leaves that valid pulse intact.
        start_op(OP_DIVU, 32'h55, 32'd0, 1'b0);
        kill = 1'b1;
        #1;
        chk("killdone_valid", {31'd0, valid_f}, 32'd1);
        chk("killdone_res", res_f, model(OP_DIVU, 32'h55, 32'd0));
        last_f = model(OP_DIVU, 32'h55, 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        chk("killdone_busy", {30'd0, busy_f, busy_s}, 32'd0);
        chk("killdone_res_s", res_s, last_s);
        quiet("killdone_q", 36);

        // Reset sampled 20 edges after acceptance.
        start_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_flags", {28'd0, busy_f, valid_f, busy_s, valid_s}, 32'd0);
        chk("midrst_res_f", res_f, 32'd0);
        chk("midrst_res_s", res_s, 32'd0);
        last_f = 32'd0;
        last_s = 32'd0;
        run("after_rst", OP_REM, 32'd100, 32'hFFFF_FFF9);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run("rand", ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
